// File: rtl/toy_pack.sv
// Shared fetch-path types and sizing for the toy I-cache.
// Line geometry is 4 beats x 128 bits = 64-byte lines, 64 sets.
package toy_pack;

  localparam int ICACHE_INDEX_WIDTH = 6;
  localparam int ICACHE_LINE_BEATS  = 4;
  localparam int ICACHE_BEAT_WIDTH  = 128;

  localparam logic [1:0] UPSTREAM_OPCODE = 2'd1;
  localparam logic [1:0] PREFETCH_OPCODE = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  opcode;
    logic [4:0]  txnid;
  } pc_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    RSP  = 2'd3
  } icache_miss_state_e;

endpackage

// File: rtl/icache_miss_ctrl.sv
// Blocking I-cache miss handler: one outstanding line fill, beats written through
// to the data array as they arrive, requested beat returned to the fetch unit.
module icache_miss_ctrl
  import toy_pack::*;
#(
  parameter int BEAT_WIDTH  = ICACHE_BEAT_WIDTH,
  parameter int LINE_BEATS  = ICACHE_LINE_BEATS,
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lkp_vld,
  input  pc_req_t                       lkp_pld,
  input  logic                          lkp_miss,
  input  logic                          lkp_victim,
  output logic                          stall,
  output logic                          dn_req_vld,
  input  logic                          dn_req_rdy,
  output logic [31:0]                   dn_req_addr,
  output logic [4:0]                    dn_req_txnid,
  input  logic                          rf_vld,
  input  logic [BEAT_WIDTH-1:0]         rf_data,
  output logic                          da_wr_en,
  output logic                          da_way,
  output logic [INDEX_WIDTH-1:0]        da_index,
  output logic [$clog2(LINE_BEATS)-1:0] da_beat,
  output logic [BEAT_WIDTH-1:0]         da_wdata,
  output logic                          up_rsp_vld,
  input  logic                          up_rsp_rdy,
  output logic [BEAT_WIDTH-1:0]         up_rsp_data,
  output logic [4:0]                    up_rsp_txnid,
  output logic                          err
);

  localparam int BW       = $clog2(LINE_BEATS);
  localparam int BYTE_OFF = $clog2(BEAT_WIDTH / 8);
  localparam int LINE_OFF = BYTE_OFF + BW;
  localparam logic [31:0]   LINE_MASK = (32'd1 << LINE_OFF) - 32'd1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

  icache_miss_state_e state;
  logic [BW-1:0]      cnt;
  logic [BW-1:0]      beat_off;
  logic               is_pf;

  logic new_miss;
  assign new_miss = lkp_vld & lkp_miss;

  // Combinational so the tag stage cannot accept the request right behind a miss.
  assign stall    = (state != IDLE) | new_miss;
  assign da_wr_en = (state == FILL) & rf_vld;
  assign da_wdata = da_wr_en ? rf_data : '0;
  assign da_beat  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      beat_off     <= '0;
      is_pf        <= 1'b0;
      dn_req_vld   <= 1'b0;
      dn_req_addr  <= '0;
      dn_req_txnid <= '0;
      da_way       <= 1'b0;
      da_index     <= '0;
      up_rsp_vld   <= 1'b0;
      up_rsp_data  <= '0;
      up_rsp_txnid <= '0;
      err          <= 1'b0;
    end else begin
      if ((rf_vld && state != FILL) || (new_miss && state != IDLE))
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (new_miss) begin
            dn_req_addr  <= lkp_pld.addr & ~LINE_MASK;
            dn_req_txnid <= lkp_pld.txnid;
            up_rsp_txnid <= lkp_pld.txnid;
            da_way       <= lkp_victim;
            da_index     <= lkp_pld.addr[LINE_OFF +: INDEX_WIDTH];
            beat_off     <= lkp_pld.addr[LINE_OFF-1:BYTE_OFF];
            is_pf        <= (lkp_pld.opcode == PREFETCH_OPCODE);
            dn_req_vld   <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (dn_req_rdy) begin
            dn_req_vld <= 1'b0;
            cnt        <= '0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (rf_vld) begin
            if (cnt == beat_off)
              up_rsp_data <= rf_data;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              cnt <= '0;
              if (is_pf) begin
                state <= IDLE;
              end else begin
                up_rsp_vld <= 1'b1;
                state      <= RSP;
              end
            end
          end
        end
        RSP: begin
          if (up_rsp_rdy) begin
            up_rsp_vld <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Directed bench for icache_miss_ctrl: inputs change 1ns after the rising edge,
// outputs are checked 2ns after it.
module tb_icache_miss_ctrl;
  import toy_pack::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lkp_vld, lkp_miss, lkp_victim;
  pc_req_t      lkp_pld;
  logic         stall, dn_req_vld, dn_req_rdy;
  logic [31:0]  dn_req_addr;
  logic [4:0]   dn_req_txnid;
  logic         rf_vld;
  logic [127:0] rf_data;
  logic         da_wr_en, da_way;
  logic [5:0]   da_index;
  logic [1:0]   da_beat;
  logic [127:0] da_wdata;
  logic         up_rsp_vld, up_rsp_rdy;
  logic [127:0] up_rsp_data;
  logic [4:0]   up_rsp_txnid;
  logic         err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_miss_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lkp_vld(lkp_vld), .lkp_pld(lkp_pld), .lkp_miss(lkp_miss), .lkp_victim(lkp_victim),
    .stall(stall),
    .dn_req_vld(dn_req_vld), .dn_req_rdy(dn_req_rdy),
    .dn_req_addr(dn_req_addr), .dn_req_txnid(dn_req_txnid),
    .rf_vld(rf_vld), .rf_data(rf_data),
    .da_wr_en(da_wr_en), .da_way(da_way), .da_index(da_index),
    .da_beat(da_beat), .da_wdata(da_wdata),
    .up_rsp_vld(up_rsp_vld), .up_rsp_rdy(up_rsp_rdy),
    .up_rsp_data(up_rsp_data), .up_rsp_txnid(up_rsp_txnid),
    .err(err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a miss for one cycle; stall must rise in that same cycle.
  task automatic miss(input logic [31:0] addr, input logic [1:0] op,
                      input logic [4:0] txn, input logic vic);
    lkp_vld = 1'b1; lkp_miss = 1'b1; lkp_victim = vic;
    lkp_pld = '{addr: addr, opcode: op, txnid: txn};
    #1 check("stall_on_miss", stall, 1'b1);
    tick();
    lkp_vld = 1'b0; lkp_miss = 1'b0; lkp_victim = 1'b0; lkp_pld = '0;
  endtask

  task automatic fill(input logic vic, input logic [5:0] idx,
                      input logic [127:0] base, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      rf_vld = 1'b1; rf_data = base + 128'(b);
      #1;
      check("da_wr_en", da_wr_en, 1'b1);
      check("da_way", da_way, vic);
      check("da_index", da_index, idx);
      check("da_beat", da_beat, 128'(b));
      check("da_wdata", da_wdata, base + 128'(b));
      tick();
    end
    rf_vld = 1'b0; rf_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; lkp_vld = 1'b0; lkp_miss = 1'b0; lkp_victim = 1'b0; lkp_pld = '0;
    dn_req_rdy = 1'b1; rf_vld = 1'b0; rf_data = '0; up_rsp_rdy = 1'b1;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_dn_vld", dn_req_vld, 1'b0);
    check("rst_dn_addr", dn_req_addr, 32'h0);
    check("rst_rsp_vld", up_rsp_vld, 1'b0);
    check("rst_err", err, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single miss, addr 0x1234: index 8, beat offset 3, victim way1.
    miss(32'h0000_1234, UPSTREAM_OPCODE, 5'd5, 1'b1);
    #1;
    check("a_dn_vld", dn_req_vld, 1'b1);
    check("a_dn_addr", dn_req_addr, 32'h0000_1200);
    check("a_dn_txnid", dn_req_txnid, 5'd5);
    tick();
    fill(1'b1, 6'd8, 128'hA0, 4);
    #1;
    check("a_rsp_vld", up_rsp_vld, 1'b1);
    check("a_rsp_data", up_rsp_data, 128'hA3);
    check("a_rsp_txnid", up_rsp_txnid, 5'd5);
    check("a_stall_rsp", stall, 1'b1);
    tick();
    #1;
    check("a_stall_idle", stall, 1'b0);
    check("a_rsp_clr", up_rsp_vld, 1'b0);
    tick();

    // Downstream back-pressure: addr 0xABC0 -> index 0x2F, offset 0, way0.
    dn_req_rdy = 1'b0;
    miss(32'h0000_ABC0, UPSTREAM_OPCODE, 5'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("b_dn_vld", dn_req_vld, 1'b1);
      check("b_dn_addr", dn_req_addr, 32'h0000_ABC0);
      check("b_dn_txnid", dn_req_txnid, 5'd9);
      check("b_no_wr", da_wr_en, 1'b0);
      tick();
    end
    dn_req_rdy = 1'b1;
    tick();
    #1 check("b_dn_drop", dn_req_vld, 1'b0);
    fill(1'b0, 6'h2F, 128'hB0, 4);
    #1;
    check("b_rsp_data", up_rsp_data, 128'hB0);
    check("b_rsp_txnid", up_rsp_txnid, 5'd9);
    tick();

    // Prefetch miss: addr 0x40 -> index 1; no response, idle right after last beat.
    miss(32'h0000_0040, PREFETCH_OPCODE, 5'd3, 1'b0);
    tick();
    fill(1'b0, 6'd1, 128'hC0, 4);
    #1;
    check("c_no_rsp", up_rsp_vld, 1'b0);
    check("c_idle", stall, 1'b0);
    tick();

    // Hits in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      lkp_vld = 1'b1; lkp_miss = 1'b0; lkp_pld = '{addr: 32'h500 + 32'(i), opcode: UPSTREAM_OPCODE, txnid: 5'd1};
      #1 check("d_hit_stall", stall, 1'b0);
      tick();
      #1 check("d_hit_dn", dn_req_vld, 1'b0);
    end
    lkp_vld = 1'b0; lkp_pld = '0;
    check("d_err", err, 1'b0);
    tick();

    // Response back-pressure plus a stray beat: addr 0x2010 -> index 0, offset 1.
    miss(32'h0000_2010, UPSTREAM_OPCODE, 5'd17, 1'b1);
    tick();
    fill(1'b1, 6'd0, 128'hD0, 4);
    up_rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin rf_vld = 1'b1; rf_data = 128'hFF; end
      #1;
      check("e_rsp_vld", up_rsp_vld, 1'b1);
      check("e_stall", stall, 1'b1);
      check("e_rsp_data", up_rsp_data, 128'hD1);
      check("e_no_wr", da_wr_en, 1'b0);
      tick();
      rf_vld = 1'b0; rf_data = '0;
    end
    #1 check("e_err", err, 1'b1);
    up_rsp_rdy = 1'b1;
    check("e_txnid", up_rsp_txnid, 5'd17);
    tick();
    #1;
    check("e_rsp_clr", up_rsp_vld, 1'b0);
    check("e_idle", stall, 1'b0);
    tick();

    // Reset mid-fill after beats 0..2.
    miss(32'h0000_3030, UPSTREAM_OPCODE, 5'd21, 1'b1);
    tick();
    fill(1'b1, 6'd0, 128'h30, 3);
    rf_vld = 1'b1; rf_data = 128'h33; rst_n = 1'b0;
    #1;
    check("f_rst_wr", da_wr_en, 1'b0);
    check("f_rst_wdata", da_wdata, 128'h0);
    check("f_rst_beat", da_beat, 2'd0);
    check("f_rst_stall", stall, 1'b0);
    check("f_rst_err", err, 1'b0);
    check("f_rst_txnid", up_rsp_txnid, 5'd0);
    tick();
    rf_vld = 1'b0; rf_data = '0; rst_n = 1'b1;
    tick();
    #1 check("f_no_rsp", up_rsp_vld, 1'b0);
    miss(32'h0000_1234, UPSTREAM_OPCODE, 5'd7, 1'b0);
    tick();
    fill(1'b0, 6'd8, 128'hE0, 4);
    #1;
    check("f_rsp_vld", up_rsp_vld, 1'b1);
    check("f_rsp_data", up_rsp_data, 128'hE3);
    check("f_rsp_txnid", up_rsp_txnid, 5'd7);
    tick();
    #1 check("f_idle", stall, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_miss_ctrl.md
# icache_miss_ctrl

Blocking I-cache miss handler that sits directly downstream of the tag lookup stage. It captures a lookup that missed, stalls the tag stage, and issues one line-fill read downstream. It then writes the returning beats into the data array way chosen by the tag stage's LRU pick, and returns the requested beat upstream. Only one miss is outstanding at a time.

## Interface
Parameters:
- BEAT_WIDTH, 128, data bits per refill beat and per data-array write
- LINE_BEATS, 4, beats per cache line (power of two, ≥2)
- INDEX_WIDTH, ICACHE_INDEX_WIDTH, data-array set index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- lkp_vld  in  1  tag-stage result valid; one cycle after the tag request was accepted
- lkp_pld  in  pc_req_t  request payload that produced the lookup (addr, opcode, txnid)
- lkp_miss  in  1  tag miss for lkp_pld
- lkp_victim  in  1  LRU pick from tag stage; 0 = way0, 1 = way1
- stall  out  1  to tag stage; blocks acceptance of new tag requests
- dn_req_vld  out  1  line-fill read request valid
- dn_req_rdy  in  1  downstream accepts request
- dn_req_addr  out  32  line-aligned address (offset bits zero)
- dn_req_txnid  out  5  txnid of the missing request
- rf_vld  in  1  refill beat valid; no back-pressure, beats arrive in order 0..LINE_BEATS-1
- rf_data  in  BEAT_WIDTH  refill beat data
- da_wr_en  out  1  data-array write strobe
- da_way  out  1  way written
- da_index  out  INDEX_WIDTH  set written
- da_beat  out  $clog2(LINE_BEATS)  beat slot written
- da_wdata  out  BEAT_WIDTH  write data (rf_data, unregistered)
- up_rsp_vld  out  1  fill response to fetch unit
- up_rsp_rdy  in  1  fetch unit accepts response
- up_rsp_data  out  BEAT_WIDTH  beat selected by the request's beat offset
- up_rsp_txnid  out  5  txnid of the original request
- err  out  1  sticky protocol error

## Operation
- States: IDLE, REQ, FILL, RSP.
- IDLE:
  - lkp_vld & lkp_miss: capture pld and victim, go to REQ.
  - lkp_vld & !lkp_miss: ignored; hits are served by the data path.
- REQ: dn_req_vld=1 with address and txnid held stable until dn_req_rdy. On the handshake, beat counter cleared and state goes to FILL.
- FILL: each rf_vld beat drives da_wr_en=1 that cycle, with da_way=victim, da_index=captured index, da_beat=counter. The counter increments per beat. The beat whose counter equals the captured beat offset is latched into the response register. On the last beat (counter==LINE_BEATS-1):
  - opcode==PREFETCH_OPCODE: go to IDLE.
  - otherwise: go to RSP.
- RSP: up_rsp_vld=1 until up_rsp_rdy, then IDLE.
- stall = (state!=IDLE) | (lkp_vld & lkp_miss). It is combinational so that the request following a miss is not accepted.
- err is set when:
  - rf_vld arrives outside FILL (beat dropped, no da write), or
  - lkp_vld & lkp_miss arrives while state!=IDLE (lookup dropped).
- err clears only on reset.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; err 0. Reset mid-fill abandons the line: no further da writes and no response.
- Miss at cycle T: stall high at T. dn_req_vld high at T+1. If dn_req_rdy is high at T+1, the first beat can be written at T+2.
- Beat written in the same cycle rf_vld is seen (zero-latency write-through).
- Last beat at cycle F: up_rsp_vld high at F+1. If up_rsp_rdy is held high, IDLE and stall low at F+2.
- Back-to-back misses: a new miss can be captured in the cycle state returns to IDLE.
- Counter width $clog2(LINE_BEATS). It is never compared past LINE_BEATS-1 and wraps to 0 on leaving FILL.

## Structure
- toy_pack holds pc_req_t, PREFETCH_OPCODE/UPSTREAM_OPCODE, ICACHE_INDEX_WIDTH, and a new ICACHE_LINE_BEATS and ICACHE_BEAT_WIDTH. Offset and index slices come from the pc_req_t address fields.
- Add a state enum icache_miss_state_e to toy_pack.
- Single flat module; no sub-modules.

## Test plan
- Single miss, addr 0x0000_1234, victim 1, dn_req_rdy high, 4 beats of 0xA0..0xA3 → dn_req_addr 0x0000_1200 (offset bits zeroed). Four writes way1 with beats 0..3. up_rsp_data equals the beat matching the captured offset; txnid echoed; stall low 2 cycles after the last beat.
- dn_req_rdy low for 5 cycles → dn_req_vld, addr and txnid stable across all 5; no da writes before the handshake.
- Prefetch miss → four da writes, no up_rsp_vld, return to IDLE one cycle after the last beat.
- Hit lookups (lkp_miss=0) in IDLE → stall stays 0, no downstream activity.
- up_rsp_rdy low 3 cycles in RSP → stall and up_rsp_vld held; stray rf_vld during RSP sets err with no da write.
- Assert rst_n low after beat 2 → all outputs 0 immediately. After release, a fresh miss completes normally with beat count starting at 0.
